// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: reset/stall
// polarities, the default reset vector and the fetch FSM state encoding.
package fetch_pc_unit_pkg;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_latch.sv
// Remembers flush/branch redirects that arrive while the PC cannot advance,
// and resolves the next PC with priority flush > branch > sequential.
module fetch_redirect_latch
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              consume,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] seq_pc,
    output logic              redirect_flush,
    output logic [ADDR_W-1:0] next_pc
);

    logic              pending_flush_q, pending_flush_d;
    logic              pending_branch_q, pending_branch_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              eff_branch;

    // One target register suffices: a flush both wins over and clears a branch.
    always_comb begin
        redirect_flush = flush | pending_flush_q;
        eff_branch     = ~redirect_flush & (branch_flag | pending_branch_q);
        if (flush)
            next_pc = flush_pc;
        else if (pending_flush_q)
            next_pc = target_q;
        else if (eff_branch)
            next_pc = branch_flag ? branch_target : target_q;
        else
            next_pc = seq_pc;
    end

    always_comb begin
        pending_flush_d  = pending_flush_q;
        pending_branch_d = pending_branch_q;
        target_d         = target_q;
        if (en) begin
            if (consume) begin
                pending_flush_d  = 1'b0;
                pending_branch_d = 1'b0;
            end else if (flush) begin
                pending_flush_d  = 1'b1;
                pending_branch_d = 1'b0;
                target_d         = flush_pc;
            end else if (branch_flag && !pending_flush_q) begin
                pending_branch_d = 1'b1;
                target_d         = branch_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pending_flush_q  <= 1'b0;
            pending_branch_q <= 1'b0;
            target_q         <= '0;
        end else begin
            pending_flush_q  <= pending_flush_d;
            pending_branch_q <= pending_branch_d;
            target_q         <= target_d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake
// and presents {pc, inst, valid} to IF/ID, holding it while IF is stalled.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          ADDR_W       = 32,
    parameter int          INST_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ack,
    input  logic [INST_W-1:0] inst_rdata,
    output logic              stall_req,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              valid_out,
    output logic [1:0]        state_dbg
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic              consume;
    logic              redirect_flush;
    logic [ADDR_W-1:0] next_pc;

    fetch_redirect_latch #(.ADDR_W(ADDR_W)) u_redirect (
        .clk           (clk),
        .rst           (rst),
        .en            (state_q != FETCH_BOOT),
        .consume       (consume),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .seq_pc        (pc_q + ADDR_W'(4)),
        .redirect_flush(redirect_flush),
        .next_pc       (next_pc)
    );

    assign state_dbg = state_q;
    assign inst_addr = inst_req ? pc_q : '0;

    // Handshake: a fetch is outstanding while inst_req=1 and inst_ack=0;
    // inst_addr is stable for that whole span and data is taken on the ack cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        consume     = 1'b0;
        inst_req    = 1'b0;
        stall_req   = 1'b0;
        valid_out   = 1'b0;
        pc_out      = '0;
        inst_out    = '0;
        unique case (state_q)
            FETCH_BOOT: state_d = FETCH_REQ;
            FETCH_REQ: begin
                inst_req  = 1'b1;
                stall_req = ~inst_ack;
                if (inst_ack) begin
                    if (redirect_flush) begin
                        consume = 1'b1;
                        pc_d    = next_pc;
                    end else begin
                        valid_out = 1'b1;
                        inst_out  = inst_rdata;
                        pc_out    = pc_q;
                        if (stall_if == NO_STOP) begin
                            consume = 1'b1;
                            pc_d    = next_pc;
                        end else begin
                            hold_pc_d   = pc_q;
                            hold_inst_d = inst_rdata;
                            state_d     = FETCH_HOLD;
                        end
                    end
                end
            end
            FETCH_HOLD: begin
                if (flush) begin
                    consume = 1'b1;
                    pc_d    = next_pc;
                    state_d = FETCH_REQ;
                end else begin
                    valid_out = 1'b1;
                    inst_out  = hold_inst_q;
                    pc_out    = hold_pc_q;
                    if (stall_if == NO_STOP) begin
                        consume = 1'b1;
                        pc_d    = next_pc;
                        state_d = FETCH_REQ;
                    end
                end
            end
            default: state_d = FETCH_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q     <= FETCH_BOOT;
            pc_q        <= RESET_VECTOR[ADDR_W-1:0];
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; memory returns {addr[15:0], 16'hC0DE}
// unless a specific instruction word is forced.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        inst_ack = 1'b0;
    logic [31:0] inst_rdata;
    logic        inst_req, stall_req, valid_out;
    logic [31:0] inst_addr, pc_out, inst_out;
    logic [1:0]  state_dbg;
    logic        force_en = 1'b0;
    logic [31:0] force_data = '0;

    int errors = 0;
    int checks = 0;

    assign inst_rdata = force_en ? force_data : {inst_addr[15:0], 16'hC0DE};

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .flush(flush), .flush_pc(flush_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
        .inst_rdata(inst_rdata), .stall_req(stall_req), .pc_out(pc_out),
        .inst_out(inst_out), .valid_out(valid_out), .state_dbg(state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in REQ at the reset vector, one cycle after BOOT.
    task automatic do_reset();
        rst = 1'b0; inst_ack = 1'b0; stall_if = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        force_en = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc[3];
        logic [31:0] exp_inst[3];
        exp_pc   = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
        exp_inst = '{32'h0000_C0DE, 32'h0004_C0DE, 32'h0008_C0DE};
        inst_ack = 1'b1;
        @(negedge clk);
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", inst_req); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_out); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", inst_out); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_req); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", inst_req); end
        checks++; if (state_dbg !== FETCH_BOOT) begin errors++; $display("FAIL boot_state: got %0d want %0d", state_dbg, FETCH_BOOT); end
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (pc_out !== exp_pc[k]) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", k, pc_out, exp_pc[k]); end
            checks++; if (inst_out !== exp_inst[k]) begin errors++; $display("FAIL seq_inst%0d: got %h want %h", k, inst_out, exp_inst[k]); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", k, valid_out); end
            tick();
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL wait_stall%0d: got %b want 1", i, stall_req); end
            checks++; if (inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL wait_addr%0d: got %h want bfc00000", i, inst_addr); end
            checks++; if ({valid_out, inst_out} !== 33'h0) begin errors++; $display("FAIL wait_out%0d: got %b/%h want 0/0", i, valid_out, inst_out); end
            tick();
        end
        inst_ack = 1'b1;
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || inst_out !== 32'h0000_C0DE) begin errors++; $display("FAIL ack_out: got %b/%h want 1/0000c0de", valid_out, inst_out); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL ack_stall: got %b want 0", stall_req); end
        tick();
        inst_ack = 1'b0;
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL ack_next: got %h want bfc00004", inst_addr); end
    endtask

    task automatic test_hold();
        do_reset();
        inst_ack = 1'b1; stall_if = 1'b1; force_en = 1'b1; force_data = 32'h2402_0005;
        @(negedge clk);
        checks++; if (inst_out !== 32'h2402_0005) begin errors++; $display("FAIL hold_capture: got %h want 24020005", inst_out); end
        tick();
        force_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall_if = 1'b0;
            @(negedge clk);
            checks++; if (state_dbg !== FETCH_HOLD) begin errors++; $display("FAIL hold_state%0d: got %0d want %0d", i, state_dbg, FETCH_HOLD); end
            checks++; if ({inst_req, stall_req, valid_out} !== 3'b001) begin errors++; $display("FAIL hold_ctl%0d: got %b want 001", i, {inst_req, stall_req, valid_out}); end
            checks++; if (inst_out !== 32'h2402_0005 || pc_out !== 32'hBFC0_0000) begin errors++; $display("FAIL hold_data%0d: got %h@%h want 24020005@bfc00000", i, inst_out, pc_out); end
            tick();
        end
        @(negedge clk);
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL hold_release: got %b/%h want 1/bfc00004", inst_req, inst_addr); end
        checks++; if (inst_out !== 32'h0004_C0DE) begin errors++; $display("FAIL hold_next_inst: got %h want 0004c0de", inst_out); end
    endtask

    task automatic test_branch();
        do_reset();
        inst_ack = 1'b1;
        repeat (4) tick();
        inst_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h8000_1000;
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0010 || valid_out !== 1'b0) begin errors++; $display("FAIL br_slot_wait: got %h/%b want bfc00010/0", inst_addr, valid_out); end
        tick();
        branch_flag = 1'b0;
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL br_slot_stable: got %h want bfc00010", inst_addr); end
        tick();
        inst_ack = 1'b1;
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'hBFC0_0010) begin errors++; $display("FAIL br_slot_out: got %b/%h want 1/bfc00010", valid_out, pc_out); end
        checks++; if (inst_out !== 32'h0010_C0DE) begin errors++; $display("FAIL br_slot_inst: got %h want 0010c0de", inst_out); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr !== 32'h8000_1000 || pc_out !== 32'h8000_1000) begin errors++; $display("FAIL br_target: got %h/%h want 80001000", inst_addr, pc_out); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr !== 32'h8000_1004) begin errors++; $display("FAIL br_after: got %h want 80001004", inst_addr); end
    endtask

    task automatic test_flush();
        do_reset();
        flush = 1'b1; flush_pc = 32'hBFC0_0380; branch_flag = 1'b1; branch_target = 32'h8000_2000;
        @(negedge clk);
        checks++; if ({valid_out, inst_out} !== 33'h0) begin errors++; $display("FAIL fl_noack_out: got %b/%h want 0/0", valid_out, inst_out); end
        tick();
        flush = 1'b0; branch_flag = 1'b0;
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL fl_addr_kept: got %h want bfc00000", inst_addr); end
        tick();
        inst_ack = 1'b1;
        @(negedge clk);
        checks++; if ({valid_out, inst_out} !== 33'h0) begin errors++; $display("FAIL fl_discard: got %b/%h want 0/0", valid_out, inst_out); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0380 || valid_out !== 1'b1) begin errors++; $display("FAIL fl_target: got %h/%b want bfc00380/1", inst_addr, valid_out); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0384) begin errors++; $display("FAIL fl_no_branch: got %h want bfc00384", inst_addr); end
        flush = 1'b1; flush_pc = 32'h8000_0180;
        @(negedge clk);
        checks++; if ({valid_out, inst_out} !== 33'h0) begin errors++; $display("FAIL fl_ack_discard: got %b/%h want 0/0", valid_out, inst_out); end
        tick();
        flush = 1'b0; stall_if = 1'b1;
        @(negedge clk);
        checks++; if (inst_addr !== 32'h8000_0180 || valid_out !== 1'b1) begin errors++; $display("FAIL fl_ack_target: got %h/%b want 80000180/1", inst_addr, valid_out); end
        tick();
        flush = 1'b1; flush_pc = 32'hBFC0_0200;
        @(negedge clk);
        checks++; if ({valid_out, inst_out} !== 33'h0) begin errors++; $display("FAIL fl_hold_drop: got %b/%h want 0/0", valid_out, inst_out); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== FETCH_REQ || inst_addr !== 32'hBFC0_0200) begin errors++; $display("FAIL fl_hold_target: got %0d/%h want %0d/bfc00200", state_dbg, inst_addr, FETCH_REQ); end
        stall_if = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        inst_ack = 1'b1; branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        checks++; if (pc_out !== 32'hBFC0_0000 || valid_out !== 1'b1) begin errors++; $display("FAIL wr_slot: got %h/%b want bfc00000/1", pc_out, valid_out); end
        tick();
        branch_flag = 1'b0;
        @(negedge clk);
        checks++; if (inst_addr !== 32'hFFFF_FFFC || inst_out !== 32'hFFFC_C0DE) begin errors++; $display("FAIL wr_top: got %h/%h want fffffffc/fffcc0de", inst_addr, inst_out); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr !== 32'h0 || inst_out !== 32'h0000_C0DE || valid_out !== 1'b1) begin errors++; $display("FAIL wr_zero: got %h/%h/%b want 0/0000c0de/1", inst_addr, inst_out, valid_out); end
        tick();
        inst_ack = 1'b0;
        @(negedge clk);
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h4) begin errors++; $display("FAIL mid_req: got %b/%h want 1/4", inst_req, inst_addr); end
        rst = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b0 || state_dbg !== FETCH_BOOT) begin errors++; $display("FAIL mid_drop: got %b/%0d want 0/%0d", inst_req, state_dbg, FETCH_BOOT); end
        tick();
        rst = 1'b1; inst_ack = 1'b1;
        @(negedge clk);
        checks++; if (inst_req !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL mid_boot: got %b/%b want 0/0", inst_req, valid_out); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr !== 32'hBFC0_0000 || valid_out !== 1'b1) begin errors++; $display("FAIL mid_restart: got %h/%b want bfc00000/1", inst_addr, valid_out); end
    endtask

    initial begin
        test_reset();
        test_ack_delay();
        test_hold();
        test_branch();
        test_flush();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end: owns the PC and drives the instruction-memory request/acknowledge handshake.
- Presents {pc, inst, valid} to the IF/ID pipeline register. Raises a stall request to the stall controller while a fetch is outstanding.
- Applies branch redirects (with MIPS delay-slot semantics) and exception flush redirects.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded at reset.
- ADDR_W, 32, PC and instruction-address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (`RST_ENABLE = 1'b0).
- stall_if  in  1  IF stage stall from the stall controller (`STOP/`NO_STOP).
- flush  in  1  exception flush; discards in-flight/held instruction.
- flush_pc  in  ADDR_W  exception handler target.
- branch_flag  in  1  taken branch/jump resolved in ID, single-cycle pulse.
- branch_target  in  ADDR_W  branch destination.
- inst_req  out  1  instruction-memory request.
- inst_addr  out  ADDR_W  fetch address; held stable while inst_req=1.
- inst_ack  in  1  memory response valid; data on inst_rdata same cycle.
- inst_rdata  in  INST_W  fetched instruction.
- stall_req  out  1  to stall controller: fetch outstanding.
- pc_out  out  ADDR_W  PC of the presented instruction.
- inst_out  out  INST_W  presented instruction; 0 (NOP) when valid_out=0.
- valid_out  out  1  presented instruction is real.

Behaviour:
- States: BOOT, REQ, HOLD.
- Reset (async, rst=0): pc=RESET_VECTOR; state=BOOT; pending redirect cleared; hold buffer=0; all outputs 0.
- BOOT: inst_req=0, outputs 0. Any inst_ack is ignored. Next cycle goes to REQ unconditionally.
- REQ:
  - inst_req=1, inst_addr=pc.
  - stall_req = ~inst_ack.
  - Without ack: valid_out=0.
  - With ack and no pending flush: valid_out=1, inst_out=inst_rdata, pc_out=pc (combinational pass-through). Then:
    - stall_if=`NO_STOP: pc<=next_pc, stay in REQ.
    - stall_if=`STOP: capture {pc, inst_rdata} into the hold buffer, go to HOLD.
- HOLD:
  - inst_req=0, stall_req=0, outputs driven from the hold buffer with valid_out=1.
  - When stall_if=`NO_STOP: pc<=next_pc, go to REQ.
- next_pc priority:
  1. Pending/current flush → flush_pc.
  2. Pending/current branch → branch_target.
  3. Otherwise pc+4, modulo 2^ADDR_W (wraps to 0).
- Branch semantics:
  - The instruction currently in flight or held is the delay slot and is kept.
  - The target is used for the fetch after it.
  - A branch_flag arriving in REQ without ack is latched (pending_branch, target) and consumed at the next pc update.
- Flush semantics:
  - Flush in REQ with ack in the same cycle: ack data is discarded (valid_out=0); pc<=flush_pc.
  - Flush in REQ without ack: set pending_flush; inst_addr stays unchanged until ack. That ack is discarded (valid_out=0); then pc<=flush_pc, stay in REQ.
  - Flush in HOLD: hold buffer dropped, valid_out=0 that cycle, pc<=flush_pc, go to REQ regardless of stall_if.
  - Flush clears any pending branch.
- Simultaneous flush+branch: flush wins. A second branch while one is pending overwrites it.
- Output rule: inst_out is forced to 0 whenever valid_out=0.
- Reset mid-fetch: inst_req drops immediately. The memory side shares rst. Stale acks are absorbed by BOOT.
- Latency: zero-wait memory (ack in the request cycle) sustains one instruction per cycle.
- Alignment: inst_addr is not realigned. Address-error detection is done downstream.

Decomposition:
- global_def.v owns:
  - `RST_ENABLE (1'b0), `STOP, `NO_STOP.
  - State encodings `FETCH_BOOT/`FETCH_REQ/`FETCH_HOLD.
  - Default reset vector.
- One natural sub-module: fetch_redirect_latch (pending flush/branch flags and target register with priority resolution). The FSM and hold buffer stay in the top.

Test Plan:
- Reset release, ack tied high, stall_if=0 → cycle 0 BOOT no req; then pc_out 0xBFC00000, 0xBFC00004, 0xBFC00008 with valid_out=1 every cycle.
- Ack delayed 3 cycles per fetch → stall_req=1 for 3 cycles, inst_addr stable, valid_out=1 only on ack cycle, inst_out=inst_rdata.
- stall_if=1 for 4 cycles on an ack cycle with rdata=0x24020005 → HOLD: inst_req=0, inst_out held 0x24020005, valid_out=1. Release → next fetch at pc+4.
- branch_flag with target 0x80001000 while delay slot at 0xBFC00010 awaits ack → 0xBFC00010 delivered valid; next inst_addr=0x80001000.
- flush (flush_pc=0xBFC00380) plus branch same cycle, fetch in flight → in-flight ack discarded (valid_out=0, inst_out=0); next inst_addr=0xBFC00380; branch ignored.
- PC 0xFFFFFFFC sequential → next inst_addr 0x00000000. rst pulsed low mid-fetch → inst_req drops same cycle, restart from RESET_VECTOR via BOOT.
